// File: rtl/regfile_pkg.sv
// Shared types and reset constants for the general-purpose register bank.
package regfile_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } wr_op_t;

  localparam logic RST_CARRY = 1'b0;
  localparam logic RST_ZERO  = 1'b1;
  localparam logic RST_ERR   = 1'b0;

endpackage

// File: rtl/regfile_alu.sv
// Write-port operation unit: one instance feeds both the storage update and the
// read bypass, so a bypassed read can never disagree with what gets stored.
module regfile_alu
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] wr_data,
  input  wr_op_t           wr_op,
  output logic [WIDTH-1:0] next,
  output logic             carry
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] ext;

  // NOTE: assign every combinational output a default before the case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    ext = '0;
    case (wr_op)
      OP_LOAD: ext = {1'b0, wr_data};
      OP_INC:  ext = {1'b0, cur} + ONE;
      OP_DEC:  ext = {1'b0, cur} - ONE;
      OP_CLR:  ext = '0;
      default: ext = '0;
    endcase
  end

  // The extra MSB is the carry on INC wrap and the borrow on DEC wrap.
  assign next  = ext[WIDTH-1:0];
  assign carry = ext[WIDTH];

endmodule

// File: rtl/register_file_nbit.sv
// DEPTH x WIDTH register bank: one synchronous write port with load/inc/dec/clr,
// two combinational read ports with optional write-to-read bypass.
module register_file_nbit
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  wr_op_t           wr_op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             wr_err
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] alu_next;
  logic             alu_carry;
  logic             wr_in_range;
  logic             rd_in_range_a;
  logic             rd_in_range_b;
  logic             byp_a;
  logic             byp_b;

  assign wr_in_range   = 32'(wr_addr)   < DEPTH;
  assign rd_in_range_a = 32'(rd_addr_a) < DEPTH;
  assign rd_in_range_b = 32'(rd_addr_b) < DEPTH;
  assign cur_val       = wr_in_range ? regs[wr_addr] : '0;

  regfile_alu #(.WIDTH(WIDTH)) u_alu (
    .cur     (cur_val),
    .wr_data (wr_data),
    .wr_op   (wr_op),
    .next    (alu_next),
    .carry   (alu_carry)
  );

  // Bypass is suppressed during reset so reads show the cleared bank at once.
  assign byp_a = BYPASS && reset && we && wr_in_range && (rd_addr_a == wr_addr);
  assign byp_b = BYPASS && reset && we && wr_in_range && (rd_addr_b == wr_addr);

  assign rd_data_a = !rd_in_range_a ? '0 : (byp_a ? alu_next : regs[rd_addr_a]);
  assign rd_data_b = !rd_in_range_b ? '0 : (byp_b ? alu_next : regs[rd_addr_b]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the bank is small and architecturally defined as zero after reset, so every entry is cleared here.
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
      carry_flag <= RST_CARRY;
      zero_flag  <= RST_ZERO;
      wr_err     <= RST_ERR;
    end else begin
      wr_err <= we && !wr_in_range;
      if (we && wr_in_range) begin
        regs[wr_addr] <= alu_next;
        carry_flag    <= alu_carry;
        zero_flag     <= (alu_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_register_file_nbit.sv
// Drives three register banks (bypass, no bypass, DEPTH=3) with shared stimulus
// and compares each against an array-based reference model.
module tb_register_file_nbit;
  import regfile_pkg::*;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  wr_op_t     wr_op;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;

  logic [7:0] rd_a [NDUT];
  logic [7:0] rd_b [NDUT];
  logic       cf   [NDUT];
  logic       zf   [NDUT];
  logic       er   [NDUT];

  int checks = 0;
  int errors = 0;

  int mem     [NDUT][4];
  bit m_carry [NDUT];
  bit m_zero  [NDUT];
  bit m_err   [NDUT];

  always #5 clk = ~clk;

  register_file_nbit #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b1)) u0 (
    .clk(clk), .reset(reset), .we(we), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a[0]), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b[0]),
    .carry_flag(cf[0]), .zero_flag(zf[0]), .wr_err(er[0]));

  register_file_nbit #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b0)) u1 (
    .clk(clk), .reset(reset), .we(we), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a[1]), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b[1]),
    .carry_flag(cf[1]), .zero_flag(zf[1]), .wr_err(er[1]));

  register_file_nbit #(.WIDTH(8), .DEPTH(3), .BYPASS(1'b1)) u2 (
    .clk(clk), .reset(reset), .we(we), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a[2]), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b[2]),
    .carry_flag(cf[2]), .zero_flag(zf[2]), .wr_err(er[2]));

  function automatic int dep_of(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic bit byp_of(int k);
    return (k != 1);
  endfunction

  function automatic int op_result(int op, int v, int d);
    case (op)
      0:       return d;
      1:       return (v + 1) % 256;
      2:       return (v + 255) % 256;
      default: return 0;
    endcase
  endfunction

  function automatic bit op_carry(int op, int v);
    return (op == 1 && v == 255) || (op == 2 && v == 0);
  endfunction

  function automatic int exp_read(int k, int a);
    if (!reset) return 0;
    if (a >= dep_of(k)) return 0;
    if (byp_of(k) && we && int'(wr_addr) < dep_of(k) && a == int'(wr_addr))
      return op_result(int'(wr_op), mem[k][a], int'(wr_data));
    return mem[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      for (int r = 0; r < 4; r++) mem[k][r] = 0;
      m_carry[k] = 1'b0;
      m_zero[k]  = 1'b1;
      m_err[k]   = 1'b0;
    end
  endtask

  // Applies the write that the DUTs just sampled on the rising edge.
  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      if (!we) begin
        m_err[k] = 1'b0;
      end else if (int'(wr_addr) >= dep_of(k)) begin
        m_err[k] = 1'b1;
      end else begin
        int v = mem[k][wr_addr];
        int n = op_result(int'(wr_op), v, int'(wr_data));
        mem[k][wr_addr] = n;
        m_carry[k] = op_carry(int'(wr_op), v);
        m_zero[k]  = (n == 0);
        m_err[k]   = 1'b0;
      end
    end
  endtask

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_reads(string tag);
    for (int k = 0; k < NDUT; k++) begin
      check({tag, ".rd_a"}, k, 32'(rd_a[k]), 32'(exp_read(k, int'(rd_addr_a))));
      check({tag, ".rd_b"}, k, 32'(rd_b[k]), 32'(exp_read(k, int'(rd_addr_b))));
    end
  endtask

  task automatic check_flags(string tag);
    for (int k = 0; k < NDUT; k++) begin
      check({tag, ".carry"}, k, 32'(cf[k]), 32'(m_carry[k]));
      check({tag, ".zero"},  k, 32'(zf[k]), 32'(m_zero[k]));
      check({tag, ".err"},   k, 32'(er[k]), 32'(m_err[k]));
    end
  endtask

  // Reads are checked before the edge (bypass visible) and after it (new state visible).
  task automatic step(input bit w, input wr_op_t op, input int wa, input int wd,
                      input int ra, input int rb, input string tag);
    we        = w;
    wr_op     = op;
    wr_addr   = 2'(wa);
    wr_data   = 8'(wd);
    rd_addr_a = 2'(ra);
    rd_addr_b = 2'(rb);
    #1;
    check_reads({tag, ".pre"});
    @(posedge clk);
    model_edge();
    #1;
    check_flags(tag);
    check_reads({tag, ".post"});
  endtask

  initial begin
    reset = 1'b0;
    we = 1'b0; wr_op = OP_LOAD; wr_addr = '0; wr_data = '0;
    rd_addr_a = 2'd0; rd_addr_b = 2'd3;
    model_reset();
    #12;
    check_flags("reset");
    check_reads("reset");
    @(negedge clk);
    reset = 1'b1;

    step(1'b1, OP_LOAD, 1, 8'hA5, 1, 2, "load_r1");
    step(1'b1, OP_LOAD, 2, 8'h3C, 1, 2, "load_r2");
    step(1'b0, OP_LOAD, 0, 8'h00, 1, 2, "dual_read");
    step(1'b0, OP_LOAD, 0, 8'h00, 2, 2, "same_addr");

    step(1'b1, OP_LOAD, 0, 8'hFF, 0, 1, "load_ff");
    step(1'b1, OP_INC,  0, 8'h00, 0, 1, "inc_wrap");
    step(1'b1, OP_INC,  0, 8'h00, 0, 1, "inc_again");

    step(1'b1, OP_CLR,  3, 8'h00, 3, 0, "clr_r3");
    step(1'b1, OP_DEC,  3, 8'h00, 3, 0, "dec_borrow");

    step(1'b1, OP_LOAD, 1, 8'h10, 2, 0, "load_10");
    step(1'b1, OP_INC,  1, 8'h00, 1, 1, "bypass_inc");

    step(1'b1, OP_LOAD, 3, 8'h55, 3, 2, "out_of_range");
    step(1'b0, OP_LOAD, 0, 8'h00, 3, 1, "err_one_cycle");

    step(1'b1, OP_INC,  2, 8'h00, 2, 0, "inc_b2b_1");
    step(1'b1, OP_INC,  2, 8'h00, 2, 0, "inc_b2b_2");
    step(1'b1, OP_INC,  2, 8'h00, 2, 0, "inc_b2b_3");

    // Reset asserted mid-cycle while a write is pending: the write must be lost.
    we = 1'b1; wr_op = OP_LOAD; wr_addr = 2'd0; wr_data = 8'h77;
    rd_addr_a = 2'd0; rd_addr_b = 2'd2;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_flags("reset_mid");
    check_reads("reset_mid");
    @(posedge clk);
    #1;
    check_flags("reset_hold");
    check_reads("reset_hold");
    @(negedge clk);
    we = 1'b0;
    reset = 1'b1;
    step(1'b0, OP_LOAD, 0, 8'h00, 0, 1, "after_reset");

    for (int i = 0; i < 400; i++) begin
      int sel = int'($urandom_range(0, 7));
      int d   = (sel == 0) ? 8'hFF : (sel == 1) ? 0 : int'($urandom_range(0, 255));
      step(($urandom_range(0, 3) != 0), wr_op_t'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), d,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_nbit.md
Name: register_file_nbit

Overview:
- Parametrised multi-register bank; successor to the single N-bit load register.
- Holds DEPTH registers of WIDTH bits, with one synchronous write port and two asynchronous read ports.
- The write port supports load, increment, decrement and clear operations, and updates registered carry/zero flags.
- Sits in the datapath as the general-purpose register bank (A/B/scratch) feeding the ALU and bus muxes.

Parameters:
- WIDTH, 8, bits per register (>=2).
- DEPTH, 4, number of registers (>=2; need not be a power of two).
- BYPASS, 1, 1 = a read of the register being written this cycle returns the value it will take; 0 = returns the old contents.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  write enable, sampled on rising clk.
- wr_op  input  2  write operation; encoding in Behaviour.
- wr_addr  input  AW  target register; AW = max(1, $clog2(DEPTH)).
- wr_data  input  WIDTH  operand for OP_LOAD.
- rd_addr_a  input  AW  read port A address.
- rd_data_a  output  WIDTH  read port A data (combinational).
- rd_addr_b  input  AW  read port B address.
- rd_data_b  output  WIDTH  read port B data (combinational).
- carry_flag  output  1  registered carry/borrow from the last accepted write.
- zero_flag  output  1  registered; 1 when the last accepted write produced all zeros.
- wr_err  output  1  registered; 1 for one cycle after a write with wr_addr >= DEPTH.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-to-clk release):
  - All registers = 0.
  - carry_flag = 0, zero_flag = 1, wr_err = 0.
- wr_op encoding:
  - 00 OP_LOAD: reg <= wr_data, carry <= 0.
  - 01 OP_INC: reg <= reg+1 mod 2^WIDTH, carry <= 1 only on wrap from all-ones to 0.
  - 10 OP_DEC: reg <= reg-1 mod 2^WIDTH, carry (borrow) <= 1 only on wrap from 0 to all-ones.
  - 11 OP_CLR: reg <= 0, carry <= 0.
- Arithmetic: computed at WIDTH+1 bits; the MSB is carry/borrow; the result is truncated to WIDTH.
- Write timing:
  - A write with we=1 takes effect on the rising edge.
  - The new register value and flags are visible the cycle after that edge.
- When we=0:
  - Registers and carry_flag/zero_flag hold.
  - wr_err <= 0.
- Out-of-range address, wr_addr >= DEPTH with we=1:
  - No register changes; flags hold.
  - wr_err <= 1 for one cycle.
- Reads:
  - Zero latency; rd_data_x = reg[rd_addr_x].
  - rd_addr_x >= DEPTH returns 0.
- Bypass, BYPASS=1: when we=1, wr_addr is in range and rd_addr_x == wr_addr, rd_data_x returns the next value (the op result) combinationally.
- No bypass, BYPASS=0: rd_data_x returns the current stored value.
- Both read ports may address the same register; each returns identical data.
- Back-to-back INC on the same register in consecutive cycles accumulates, with no lost updates.
- Reset asserted mid-write:
  - Reset wins; the in-flight write is discarded.
  - Outputs go to reset values immediately (asynchronous).
- No other state; there is no FSM beyond per-register storage plus the flag registers.

Decomposition:
- Package regfile_pkg:
  - typedef enum logic [1:0] wr_op_t {OP_LOAD, OP_INC, OP_DEC, OP_CLR}.
  - localparam for the reset flag values.
- Sub-module regfile_alu (combinational):
  - Inputs: cur value, wr_data, wr_op.
  - Outputs: next value and carry; zero is derived from next.
  - Shared by the write path and the bypass path so both compute identical results.

Test Plan (WIDTH=8, DEPTH=4, BYPASS=1 unless noted):
- Reset:
  - Stimulus: pulse reset low mid-cycle.
  - Response: all reads 0 immediately; zero_flag=1, carry_flag=0, wr_err=0.
- Load and dual read:
  - Stimulus: LOAD r1=8'hA5, then LOAD r2=8'h3C; read A=r1, B=r2.
  - Response: A5/3C next cycle; zero_flag=0, carry_flag=0.
- INC wrap:
  - Stimulus: LOAD r0=8'hFF, then INC r0.
  - Response: r0=8'h00, carry_flag=1, zero_flag=1.
  - Then INC r0 again: r0=8'h01, carry_flag=0.
- DEC borrow:
  - Stimulus: CLR r3, then DEC r3.
  - Response: r3=8'hFF, carry_flag=1, zero_flag=0.
- Bypass:
  - BYPASS=1: r1=8'h10; same cycle INC r1 with rd_addr_a=1 gives rd_data_a=8'h11 before the edge.
  - BYPASS=0 rerun: the same stimulus shows 8'h10.
- Out-of-range:
  - DEPTH=3: LOAD to addr 3 with 8'h55 sets wr_err=1 for exactly one cycle.
  - All registers and flags unchanged; a read of addr 3 returns 0.
